// File: rtl/drv_debug_input_pkg.sv
// Shared definitions for the DE2-70 input-side debug driver:
// run/halt/step state encoding and breakpoint field positions.
package drv_debug_input_pkg;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HALT = 2'd1,
    S_STEP = 2'd2
  } dbg_state_e;

  localparam int NUM_KEYS  = 4;
  localparam int NUM_SW    = 18;
  localparam int HIST_LEN  = 3;
  localparam int BP_EN_BIT = 17;

  // Switches select a word address in the low 256 KiB; upper PC bits must be zero.
  function automatic logic [31:0] bp_address(input logic [15:0] word_idx);
    return {14'd0, word_idx, 2'b00};
  endfunction

endpackage

// File: rtl/drv_debug_input_debounce_bit.sv
// One debounced input: 2-flop synchroniser, tick-sampled 3-deep history
// and a stable level that only moves when the whole history agrees.
module debounce_bit
  import drv_debug_input_pkg::*;
#(
  parameter bit INVERT = 1'b0
) (
  input  logic CLK_I,
  input  logic RST_I,
  input  logic tick,
  input  logic raw,
  output logic stable
);

  logic [1:0]          sync_ff;
  logic [HIST_LEN-1:0] hist;
  logic [HIST_LEN-1:0] hist_next;
  logic                sample;

  // Active-low buttons are flipped here so that downstream logic sees pressed = 1.
  assign sample    = sync_ff[1] ^ INVERT;
  assign hist_next = {hist[HIST_LEN-2:0], sample};

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      sync_ff <= '0;
      hist    <= '0;
      stable  <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], raw};
      if (tick) begin
        hist <= hist_next;
        if ((&hist_next) && !stable) begin
          stable <= 1'b1;
        end else if ((~|hist_next) && stable) begin
          stable <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/drv_debug_input.sv
// Board-pin input debug driver: debounced switches/buttons, press pulses,
// and a run/halt/single-step controller with one PC breakpoint.
module drv_debug_input
  import drv_debug_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 30000
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [NUM_SW-1:0]   sw,
  input  logic [31:0]         debug_pc,
  output logic [NUM_SW-1:0]   sw_stable,
  output logic [NUM_KEYS-1:0] key_press,
  output logic                debug_sw_pc,
  output logic                debug_sw_adr,
  output logic                debug_halt,
  output logic                debug_step,
  output logic                bp_hit
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0]    presc_cnt;
  logic                tick;
  logic [NUM_KEYS-1:0] key_stable;
  logic [NUM_KEYS-1:0] key_prev;
  logic [31:0]         pc_q;
  logic [31:0]         bp_addr;
  logic                bp_match;
  logic                bp_enable;
  logic                bp_armed;
  logic                bp_fire;
  logic                bp_hit_q;
  dbg_state_e          state;
  dbg_state_e          state_next;

  assign tick = (presc_cnt == CNT_MAX);

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    debounce_bit #(.INVERT(1'b1)) u_deb (
      .CLK_I  (CLK_I),
      .RST_I  (RST_I),
      .tick   (tick),
      .raw    (key_n[i]),
      .stable (key_stable[i])
    );
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_bit #(.INVERT(1'b0)) u_deb (
      .CLK_I  (CLK_I),
      .RST_I  (RST_I),
      .tick   (tick),
      .raw    (sw[i]),
      .stable (sw_stable[i])
    );
  end

  // Press pulse coincides with the first cycle the debounced key reads pressed.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      key_prev <= '0;
    end else begin
      key_prev <= key_stable;
    end
  end

  assign key_press    = key_stable & ~key_prev;
  assign debug_sw_pc  = sw_stable[0];
  assign debug_sw_adr = sw_stable[1];

  assign bp_addr   = bp_address(sw_stable[15:0]);
  assign bp_match  = (pc_q == bp_addr);
  assign bp_enable = sw_stable[BP_EN_BIT];
  assign bp_fire   = (state == S_RUN) && bp_enable && bp_armed && bp_match;

  // Disarm on hit so a resume at the same PC does not halt again until the PC moves away.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      pc_q     <= '0;
      bp_armed <= 1'b1;
      bp_hit_q <= 1'b0;
    end else begin
      pc_q     <= debug_pc;
      bp_hit_q <= bp_fire;
      if (bp_fire) begin
        bp_armed <= 1'b0;
      end else if (!bp_match) begin
        bp_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state <= S_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RUN: begin
        if (key_press[0] || bp_fire) begin
          state_next = S_HALT;
        end
      end
      S_HALT: begin
        if (key_press[0]) begin
          state_next = S_RUN;
        end else if (key_press[1]) begin
          state_next = S_STEP;
        end
      end
      S_STEP: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_RUN;
      end
    endcase
  end

  assign debug_halt = (state == S_HALT);
  assign debug_step = (state == S_STEP);
  assign bp_hit     = bp_hit_q;

endmodule

// File: tb/tb_drv_debug_input.sv
// Scoreboard bench for drv_debug_input: stimulus queues expected output
// frames, a negedge monitor compares every cycle in which an output event occurs.
module tb_drv_debug_input;

  localparam int DEB = 4;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic [3:0]  key_n;
  logic [17:0] sw;
  logic [31:0] debug_pc;
  logic [17:0] sw_stable;
  logic [3:0]  key_press;
  logic        debug_sw_pc;
  logic        debug_sw_adr;
  logic        debug_halt;
  logic        debug_step;
  logic        bp_hit;

  always #5 CLK_I = ~CLK_I;

  drv_debug_input #(.DEBOUNCE_CYCLES(DEB)) dut (
    .CLK_I        (CLK_I),
    .RST_I        (RST_I),
    .key_n        (key_n),
    .sw           (sw),
    .debug_pc     (debug_pc),
    .sw_stable    (sw_stable),
    .key_press    (key_press),
    .debug_sw_pc  (debug_sw_pc),
    .debug_sw_adr (debug_sw_adr),
    .debug_halt   (debug_halt),
    .debug_step   (debug_step),
    .bp_hit       (bp_hit)
  );

  typedef struct {
    logic [3:0]  kp;
    logic        bp;
    logic        step;
    logic        halt;
    logic [17:0] sw;
    int          lo;
    int          hi;
  } frame_t;

  frame_t      exp_q[$];
  frame_t      mon_f;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  logic        prev_halt;
  logic [17:0] prev_sw;
  logic [17:0] exp_sw;

  always @(posedge CLK_I) cyc <= cyc + 1;

  task automatic push_frame(input logic [3:0] kp, input logic bp, input logic step,
                            input logic halt, input int lo, input int hi);
    frame_t f;
    f.kp = kp; f.bp = bp; f.step = step; f.halt = halt; f.sw = exp_sw;
    f.lo = lo; f.hi = hi;
    exp_q.push_back(f);
  endtask

  task automatic check_output(input frame_t e, input int c);
    bit ok;
    ok = (key_press === e.kp) && (bp_hit === e.bp) && (debug_step === e.step) &&
         (debug_halt === e.halt) && (sw_stable === e.sw) &&
         (debug_sw_pc === e.sw[0]) && (debug_sw_adr === e.sw[1]) &&
         (e.lo < 0 || c >= e.lo) && (e.hi < 0 || c <= e.hi);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL event at cycle %0d: got kp=%b bp=%b step=%b halt=%b sw=%h swpc=%b swadr=%b, required kp=%b bp=%b step=%b halt=%b sw=%h in cycles [%0d,%0d]",
               c, key_press, bp_hit, debug_step, debug_halt, sw_stable, debug_sw_pc,
               debug_sw_adr, e.kp, e.bp, e.step, e.halt, e.sw, e.lo, e.hi);
    end
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Any pulse or level change is an output event and must match the next queued frame.
  always @(negedge CLK_I) begin
    if (mon_en) begin
      if (key_press != 4'd0 || bp_hit || debug_step ||
          debug_halt !== prev_halt || sw_stable !== prev_sw) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL unexpected event at cycle %0d: kp=%b bp=%b step=%b halt=%b sw=%h, required no event",
                   cyc, key_press, bp_hit, debug_step, debug_halt, sw_stable);
        end else begin
          mon_f = exp_q.pop_front();
          check_output(mon_f, cyc);
        end
      end
      prev_halt = debug_halt;
      prev_sw   = sw_stable;
    end
  end

  task automatic tick_clk(input int n);
    repeat (n) @(posedge CLK_I);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] kn, input logic [17:0] s, input logic [31:0] pc);
    tick_clk(1);
    key_n    = kn;
    sw       = s;
    debug_pc = pc;
  endtask

  task automatic press_keys(input logic [3:0] mask);
    key_n = ~mask;
    tick_clk(24);
    key_n = 4'hF;
    tick_clk(24);
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max_cyc) begin
      tick_clk(1);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL %s timeout: %0d expected events pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  found;

    RST_I    = 1'b1;
    key_n    = 4'hF;
    sw       = 18'h3FFFF;
    debug_pc = 32'h0;
    exp_sw   = 18'h0;

    tick_clk(1);
    @(negedge CLK_I);
    check_eq("reset sw_stable", {14'd0, sw_stable}, 32'h0);
    check_eq("reset key_press", {28'd0, key_press}, 32'h0);
    check_eq("reset debug_halt", {31'd0, debug_halt}, 32'h0);
    check_eq("reset debug_step", {31'd0, debug_step}, 32'h0);
    check_eq("reset bp_hit", {31'd0, bp_hit}, 32'h0);
    check_eq("reset debug_sw_pc", {31'd0, debug_sw_pc}, 32'h0);
    check_eq("reset debug_sw_adr", {31'd0, debug_sw_adr}, 32'h0);
    tick_clk(2);
    RST_I     = 1'b0;
    prev_halt = 1'b0;
    prev_sw   = 18'h0;
    mon_en    = 1'b1;
    exp_sw    = 18'h3FFFF;
    push_frame(4'b0000, 0, 0, 0, cyc + 1, cyc + 18);
    wait_drain("reset_fill", 40);

    apply_stimulus(4'hF, 18'h0, 32'h0);
    exp_sw = 18'h0;
    push_frame(4'b0000, 0, 0, 0, -1, -1);
    wait_drain("sw_clear", 40);

    // Toggle period 6 against tick period 4 never lets three samples agree.
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) key_n[0] = ~key_n[0];
      tick_clk(1);
    end
    key_n[0] = 1'b0;
    n = cyc;
    push_frame(4'b0001, 0, 0, 0, n + 1, n + 20);
    push_frame(4'b0000, 0, 0, 1, -1, -1);
    tick_clk(30);
    key_n[0] = 1'b1;
    wait_drain("bounce", 60);
    tick_clk(30);

    push_frame(4'b0010, 0, 0, 1, -1, -1);
    push_frame(4'b0000, 0, 1, 0, -1, -1);
    push_frame(4'b0000, 0, 0, 1, -1, -1);
    press_keys(4'b0010);
    wait_drain("single_step", 40);

    push_frame(4'b0011, 0, 0, 1, -1, -1);
    push_frame(4'b0000, 0, 0, 0, -1, -1);
    press_keys(4'b0011);
    wait_drain("key0_key1_together", 40);

    apply_stimulus(4'hF, 18'h20040, 32'h0);
    exp_sw = 18'h20040;
    push_frame(4'b0000, 0, 0, 0, -1, -1);
    wait_drain("bp_switches", 40);

    apply_stimulus(4'hF, 18'h20040, 32'h100);
    n = cyc;
    push_frame(4'b0000, 1, 0, 1, n + 2, n + 2);
    tick_clk(10);
    wait_drain("bp_hit_first", 10);

    push_frame(4'b0001, 0, 0, 1, -1, -1);
    push_frame(4'b0000, 0, 0, 0, -1, -1);
    press_keys(4'b0001);
    wait_drain("bp_resume_same_pc", 40);
    tick_clk(10);

    debug_pc = 32'h104;
    tick_clk(5);
    debug_pc = 32'h100;
    n = cyc;
    push_frame(4'b0000, 1, 0, 1, n + 2, n + 2);
    tick_clk(6);
    wait_drain("bp_rearm", 10);
    push_frame(4'b0001, 0, 0, 1, -1, -1);
    push_frame(4'b0000, 0, 0, 0, -1, -1);
    press_keys(4'b0001);
    wait_drain("bp_resume2", 40);

    // Same word index but nonzero upper PC bits must not match.
    debug_pc = 32'h0004_0100;
    tick_clk(10);
    debug_pc = 32'h100;
    n = cyc;
    push_frame(4'b0000, 1, 0, 1, n + 2, n + 2);
    tick_clk(6);
    wait_drain("bp_upper_bits", 10);
    push_frame(4'b0001, 0, 0, 1, -1, -1);
    push_frame(4'b0000, 0, 0, 0, -1, -1);
    press_keys(4'b0001);
    wait_drain("bp_resume3", 40);

    apply_stimulus(4'hF, 18'h00040, 32'h100);
    exp_sw = 18'h00040;
    push_frame(4'b0000, 0, 0, 0, -1, -1);
    wait_drain("bp_disable_sw", 40);
    debug_pc = 32'h104;
    tick_clk(5);
    debug_pc = 32'h100;
    tick_clk(20);

    debug_pc = 32'h0;
    push_frame(4'b0001, 0, 0, 0, -1, -1);
    push_frame(4'b0000, 0, 0, 1, -1, -1);
    press_keys(4'b0001);
    wait_drain("halt_before_step_reset", 40);

    key_n = 4'b1101;
    push_frame(4'b0010, 0, 0, 1, -1, -1);
    push_frame(4'b0000, 0, 1, 0, -1, -1);
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge CLK_I);
      if (debug_step === 1'b1) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("[TB] FAIL step_wait: debug_step stayed 0 for 60 cycles, required 1");
    end
    RST_I  = 1'b1;
    exp_sw = 18'h0;
    push_frame(4'b0000, 0, 0, 0, -1, -1);
    tick_clk(2);
    key_n  = 4'hF;
    RST_I  = 1'b0;
    exp_sw = 18'h00040;
    push_frame(4'b0000, 0, 0, 0, -1, -1);
    wait_drain("reset_in_step", 40);
    tick_clk(10);

    // Reset lands after at most two ticks of the new values.
    apply_stimulus(4'b1011, 18'h0, 32'h0);
    tick_clk(8);
    RST_I  = 1'b1;
    exp_sw = 18'h0;
    push_frame(4'b0000, 0, 0, 0, -1, -1);
    tick_clk(1);
    key_n = 4'hF;
    tick_clk(1);
    RST_I = 1'b0;
    tick_clk(30);
    wait_drain("reset_mid_debounce", 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
